// File: rtl/prefetch_unit.sv
// ============================================================================
// prefetch_unit : in-order instruction prefetcher with a small fetch queue.
// Rev 1.0
// ============================================================================
`default_nettype none

module prefetch_unit #(
  parameter int              WORD      = 64,
  parameter int              INSTR_LEN = 32,
  parameter int              DEPTH     = 4,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pc_src,
  input  logic [WORD-1:0]      branch_target,
  output logic                 imem_req,
  output logic [WORD-1:0]      imem_addr,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  input  logic [INSTR_LEN-1:0] imem_rdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      cur_pc
);

  localparam int              PW        = $clog2(DEPTH);
  localparam int              CW        = PW + 1;
  localparam logic [CW-1:0]   FULL      = CW'(DEPTH);
  localparam logic [WORD-1:0] ALIGN_MSK = ~WORD'(3);

  logic [WORD-1:0]      fetch_pc;
  logic [WORD-1:0]      req_pc;
  logic                 outstanding;
  logic                 discard;
  logic [CW-1:0]        count;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        wr_ptr;
  logic [WORD-1:0]      pc_q    [DEPTH];
  logic [INSTR_LEN-1:0] instr_q [DEPTH];

  logic accept;
  logic push;
  logic pop;

  // Only one request in flight, so count < DEPTH alone guarantees a free slot.
  assign imem_req    = !reset && !pc_src && !outstanding && (count < FULL);
  assign imem_addr   = fetch_pc & ALIGN_MSK;
  assign accept      = imem_req && imem_ready;
  assign push        = imem_rvalid && outstanding && !discard;
  assign out_valid   = (count != '0);
  assign pop         = out_valid && out_ready;
  assign instruction = instr_q[rd_ptr];
  assign cur_pc      = pc_q[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      discard     <= 1'b0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (pc_src) begin
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fetch_pc <= branch_target & ALIGN_MSK;
      // A response landing now is simply dropped; otherwise mark the one still in flight.
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end else if (outstanding) begin
        discard <= 1'b1;
      end
    end else begin
      if (imem_rvalid) begin
        outstanding <= 1'b0;
        discard     <= 1'b0;
      end
      if (accept) begin
        outstanding <= 1'b1;
        req_pc      <= imem_addr;
        fetch_pc    <= imem_addr + WORD'(4);
      end
      if (push) begin
        pc_q[wr_ptr]    <= req_pc;
        instr_q[wr_ptr] <= imem_rdata;
        wr_ptr          <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/prefetch_unit.md
PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 Parameter WORD, default 64, address/PC width in bits.
REQ-002 Parameter INSTR_LEN, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 4, instruction queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pc_src  in  1  redirect strobe; when high, fetch restarts at branch_target.
REQ-008 branch_target  in  WORD  redirect address.
REQ-009 imem_req  out  1  instruction-memory request valid.
REQ-010 imem_addr  out  WORD  request address; bits [1:0] always 0.
REQ-011 imem_ready  in  1  memory accepts request this cycle when high with imem_req.
REQ-012 imem_rvalid  in  1  response valid; responses return in request order, latency >= 1 cycle.
REQ-013 imem_rdata  in  INSTR_LEN  response instruction.
REQ-014 out_valid  out  1  queue head holds a valid instruction.
REQ-015 out_ready  in  1  downstream accepts head this cycle.
REQ-016 instruction  out  INSTR_LEN  head instruction.
REQ-017 cur_pc  out  WORD  PC of head instruction.

Function
REQ-018 Internal fetch_pc register holds next request address; advances by 4 (mod 2^WORD, wrap silently) on each accepted request (imem_req && imem_ready).
REQ-019 At most one request outstanding; outstanding flag sets on acceptance, clears on imem_rvalid.
REQ-020 imem_req high iff not reset, pc_src low, no outstanding request, and count < DEPTH; imem_addr = fetch_pc.
REQ-021 Response (imem_rvalid, not discarded) pushes {pc_of_request, imem_rdata} into the queue tail in the same edge.
REQ-022 Pop occurs when out_valid && out_ready; head advances, count decrements.
REQ-023 Simultaneous push and pop: count unchanged, both occur, including when count == DEPTH-1 or count == 1.
REQ-024 Queue full (count == DEPTH): no new requests; an outstanding request is never issued that could overflow (guaranteed by REQ-020 counting the outstanding slot, i.e. issue only when count + outstanding < DEPTH).
REQ-025 Queue empty: out_valid low; instruction and cur_pc hold last values, don't-care to consumers.
REQ-026 Redirect (pc_src high) has priority over push, pop and request: queue cleared (count=0, pointers reset), fetch_pc <= {branch_target[WORD-1:2], 2'b00}, out_valid low next cycle.
REQ-027 Redirect while a request is outstanding: discard flag sets; the next imem_rvalid is dropped (not pushed), clears discard and outstanding; no new request until then.
REQ-028 Redirect coincident with imem_rvalid: that response is dropped, no discard flag set.
REQ-029 First request after redirect issues the cycle after pc_src deasserts, earliest, subject to REQ-020.
REQ-030 pc_src on consecutive cycles: last target wins.
REQ-031 Instruction order to consumer equals PC order between redirects; no duplicates, no gaps.

Reset
REQ-032 Reset high on an edge: fetch_pc=RESET_PC, count=0, outstanding=0, discard=0, out_valid=0, imem_req=0 during reset, instruction=0, cur_pc=0.
REQ-033 Reset overrides pc_src and any in-flight response; responses arriving while reset is high or after reset for pre-reset requests are the memory model's responsibility to squash (bench resets memory with the unit).
REQ-034 First request (addr RESET_PC) issues in the first cycle with reset low.

Verification
REQ-035 Reset, out_ready=1, memory latency 1, always ready -> cur_pc sequence 0,4,8,12 with matching instructions, no gaps.
REQ-036 out_ready=0 for 20 cycles -> count saturates at 4, imem_req low when count+outstanding=4, head stays pc 0; release -> pcs 0..12 then 16 onward in order.
REQ-037 pc_src=1, branch_target=36 with queue holding 0..8 -> next cycle out_valid=0; next delivered cur_pc=36, then 40.
REQ-038 Redirect to 24 while request for 16 outstanding (latency 3) -> response for 16 dropped; next delivered cur_pc=24.
REQ-039 branch_target=0x2E -> imem_addr=0x2C; fetch_pc=2^WORD-4 -> next address wraps to 0.
REQ-040 Reset asserted mid-stream with count=3 -> next cycle out_valid=0, count=0; after release first cur_pc=RESET_PC.
